// File: rtl/qed_pkg.sv
// Shared QED definitions: opcode classes, duplicate-field layout and the
// classify/duplicate helpers used by qed_encoder.
package qed_pkg;

  localparam logic [5:0] OP_R       = 6'b111000;
  localparam logic [5:0] OP_I_ADDI  = 6'b100111;
  localparam logic [5:0] OP_I_ANDI  = 6'b101001;
  localparam logic [5:0] OP_I_ORI   = 6'b101010;
  localparam logic [5:0] OP_I_XORI  = 6'b101011;
  localparam logic [5:0] OP_I_MULI  = 6'b101100;
  localparam logic [5:0] OP_I_SHI   = 6'b101110;
  localparam logic [5:0] OP_LW_LO   = 6'b100001;
  localparam logic [5:0] OP_LW_HI   = 6'b100110;
  localparam logic [5:0] OP_SW_W    = 6'b110101;
  localparam logic [5:0] OP_SW_B    = 6'b110110;
  localparam logic [5:0] OP_SW_H    = 6'b110111;

  localparam logic [31:0] NOP_INSTR = 32'h1500_0000;

  localparam int unsigned DUP_REG_BIT   = 4;
  localparam int unsigned MEM_SPLIT_BIT = 14;

  // Register fields sit at [25:21], [20:16], [15:11]; a store keeps imm[15:11] in [25:21].
  localparam int unsigned RD_DUP_BIT     = 21 + DUP_REG_BIT;
  localparam int unsigned RA_DUP_BIT     = 16 + DUP_REG_BIT;
  localparam int unsigned RB_DUP_BIT     = 11 + DUP_REG_BIT;
  localparam int unsigned SW_MEM_DUP_BIT = 21 + (MEM_SPLIT_BIT - 11);

  typedef enum logic [2:0] {CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_UNSUP} qed_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ORIG, ST_DUP} qed_state_e;

  function automatic qed_class_e qed_classify(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    qed_classify = CLS_UNSUP;
    case (op)
      OP_R: qed_classify = CLS_R;
      OP_I_ADDI, OP_I_ANDI, OP_I_ORI,
      OP_I_XORI, OP_I_MULI, OP_I_SHI: qed_classify = CLS_I;
      OP_SW_W, OP_SW_B, OP_SW_H: qed_classify = CLS_SW;
      default: begin
        if (op >= OP_LW_LO && op <= OP_LW_HI && instr[15:14] == 2'b00)
          qed_classify = CLS_LW;
      end
    endcase
  endfunction

  function automatic logic [31:0] qed_duplicate(input logic [31:0] instr, input qed_class_e cls);
    logic [31:0] d;
    d = instr;
    case (cls)
      CLS_R: begin
        d[RD_DUP_BIT] = 1'b1;
        d[RA_DUP_BIT] = 1'b1;
        d[RB_DUP_BIT] = 1'b1;
      end
      CLS_I: begin
        d[RD_DUP_BIT] = 1'b1;
        d[RA_DUP_BIT] = 1'b1;
      end
      CLS_LW: begin
        d[RD_DUP_BIT]    = 1'b1;
        d[RA_DUP_BIT]    = 1'b1;
        d[MEM_SPLIT_BIT] = 1'b1;
      end
      CLS_SW: begin
        d[RA_DUP_BIT]     = 1'b1;
        d[RB_DUP_BIT]     = 1'b1;
        d[SW_MEM_DUP_BIT] = 1'b1;
      end
      default: d = instr;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/qed_encoder_fifo.sv
// Synchronous FIFO holding the original instructions recorded in the ORIG phase.
module qed_instr_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [31:0]       push_data,
  input  logic              pop,
  output logic [31:0]       pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/qed_encoder.sv
// QED instruction stream encoder: forwards/records originals, then replays duplicates.
// Build option: QED_UNSUPPORTED_NOP_EN records unsupported instructions and replays them as NOP.
module qed_encoder #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [31:0] NOP_INSTR = 32'h1500_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              qed_enable,
  input  logic              qed_exec_dup,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_is_dup,
  output logic              qed_ready,
  output logic [ADDR_W:0]   queue_count
);

  import qed_pkg::*;

`ifdef QED_UNSUPPORTED_NOP_EN
  localparam logic RECORD_UNSUP = 1'b1;
`else
  localparam logic RECORD_UNSUP = 1'b0;
`endif

  qed_state_e      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic            out_is_dup_q, out_is_dup_d;
  logic            qed_ready_q, qed_ready_d;

  logic            load, in_ready_c, push, pop;
  logic [31:0]     fifo_head;
  logic            fifo_full, fifo_empty;
  logic [ADDR_W:0] fifo_count, count_next;
  qed_class_e      in_cls, head_cls;

  qed_instr_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_instr),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    load         = !out_valid_q || out_ready;
    in_cls       = qed_classify(in_instr);
    head_cls     = qed_classify(fifo_head);
    in_ready_c   = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    count_next   = fifo_count;
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_is_dup_d = out_is_dup_q;
    qed_ready_d  = 1'b0;
    // A free output stage with nothing new to load drains to empty.
    if (load) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_c = load;
        if (in_valid && in_ready_c) begin
          out_valid_d  = 1'b1;
          out_instr_d  = in_instr;
          out_is_dup_d = 1'b0;
        end
        if (qed_enable) state_d = ST_ORIG;
      end
      ST_ORIG: begin
        in_ready_c = load && !fifo_full;
        if (in_valid && in_ready_c) begin
          out_valid_d  = 1'b1;
          out_instr_d  = in_instr;
          out_is_dup_d = 1'b0;
          push         = RECORD_UNSUP || (in_cls != CLS_UNSUP);
        end
        // Decide on the post-push occupancy so a same-cycle push lands before DUP.
        count_next = fifo_count + {{ADDR_W{1'b0}}, push};
        if (count_next == (ADDR_W+1)'(DEPTH))
          state_d = ST_DUP;
        else if ((qed_exec_dup || !qed_enable) && count_next != '0)
          state_d = ST_DUP;
        else if (!qed_enable)
          state_d = ST_IDLE;
      end
      ST_DUP: begin
        if (load && !fifo_empty) begin
          pop          = 1'b1;
          out_valid_d  = 1'b1;
          out_is_dup_d = 1'b1;
          out_instr_d  = (head_cls == CLS_UNSUP) ? NOP_INSTR : qed_duplicate(fifo_head, head_cls);
          if (fifo_count == (ADDR_W+1)'(1)) begin
            qed_ready_d = 1'b1;
            state_d     = qed_enable ? ST_ORIG : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_is_dup_q <= 1'b0;
      qed_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_is_dup_q <= out_is_dup_d;
      qed_ready_q  <= qed_ready_d;
    end
  end

  assign in_ready    = in_ready_c;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_is_dup  = out_is_dup_q;
  assign qed_ready   = qed_ready_q;
  assign queue_count = fifo_count;

endmodule

// File: tb/tb_qed_encoder.sv
// Self-checking bench for qed_encoder against a field-level model of the QED stream.
module tb_qed_encoder;

  localparam logic [31:0] NOP = 32'h1500_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        qed_enable = 1'b0;
  logic        qed_exec_dup = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_is_dup;
  logic        qed_ready;
  logic [4:0]  queue_count;

  int checks = 0;
  int passed = 0;
  int ready_cnt = 0;
  logic rand_bp = 1'b0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  qed_encoder #(.DEPTH(16), .ADDR_W(4), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .qed_enable(qed_enable), .qed_exec_dup(qed_exec_dup),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_is_dup(out_is_dup), .qed_ready(qed_ready), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back({out_is_dup, out_instr});
    if (qed_ready) ready_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int ref_class(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'b111000) return 0;
    if (op inside {6'b100111, 6'b101001, 6'b101100, 6'b101010, 6'b101011, 6'b101110}) return 1;
    if (op >= 6'b100001 && op <= 6'b100110 && w[15:14] == 2'b00) return 2;
    if (op inside {6'b110101, 6'b110110, 6'b110111}) return 3;
    return 4;
  endfunction

  function automatic logic ref_recorded(input logic [31:0] w);
`ifdef QED_UNSUPPORTED_NOP_EN
    return 1'b1;
`else
    return ref_class(w) != 4;
`endif
  endfunction

  // Registers move to r16-r31; memory offsets move up by 0x4000.
  function automatic logic [31:0] ref_dup(input logic [31:0] w);
    logic [31:0] r;
    logic [15:0] imm;
    int c;
    r = w;
    c = ref_class(w);
    if (c == 4) return NOP;
    if (c != 3) r[25:21] = w[25:21] | 5'd16;
    r[20:16] = w[20:16] | 5'd16;
    if (c == 0 || c == 3) r[15:11] = w[15:11] | 5'd16;
    if (c == 2) r[15:0] = w[15:0] + 16'h4000;
    if (c == 3) begin
      imm = {w[25:21], w[10:0]} | 16'h4000;
      r[25:21] = imm[15:11];
    end
    return r;
  endfunction

  function automatic void build_exp(input logic [31:0] orig[$]);
    exp_q.delete();
    foreach (orig[i]) exp_q.push_back({1'b0, orig[i]});
    foreach (orig[i]) if (ref_recorded(orig[i])) exp_q.push_back({1'b1, ref_dup(orig[i])});
  endfunction

  function automatic logic [31:0] rand_instr(input logic recordable_only);
    int k;
    logic [5:0] op;
    logic [31:0] w;
    k = int'($urandom_range(0, recordable_only ? 12 : 15));
    case (k)
      0: op = 6'h38;  1: op = 6'h27;  2: op = 6'h29;  3: op = 6'h2C;
      4: op = 6'h2A;  5: op = 6'h2B;  6: op = 6'h2E;  7: op = 6'h21;
      8: op = 6'h24;  9: op = 6'h26; 10: op = 6'h35; 11: op = 6'h36;
      12: op = 6'h37; 13: op = 6'h25; 14: op = 6'($urandom); default: op = 6'h05;
    endcase
    w = {op, 26'($urandom)};
    if (recordable_only && k >= 7 && k <= 9) w[15:14] = 2'b00;
    return w;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] w, output logic ok);
    in_instr = w;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_dup;
    qed_exec_dup = 1'b1;
    @(posedge clk); #1;
    qed_exec_dup = 1'b0;
  endtask

  task automatic wait_ready(input int target, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (ready_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic drain;
    @(posedge clk); #1;
    rand_bp = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_replay(input logic [31:0] orig[$], input logic bp, output logic ok);
    logic s;
    int base;
    ok = 1'b1;
    base = ready_cnt;
    got_q.delete();
    rand_bp = bp;
    foreach (orig[i]) begin
      send(orig[i], s);
      if (!s) ok = 1'b0;
    end
    pulse_dup();
    wait_ready(base + 1, s);
    if (!s) ok = 1'b0;
    drain();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_instr !== NOP) $display("FAIL reset_out_instr got %h want %h", out_instr, NOP); else passed++;
    checks++; if (out_is_dup !== 1'b0) $display("FAIL reset_out_is_dup got %b want 0", out_is_dup); else passed++;
    checks++; if (qed_ready !== 1'b0) $display("FAIL reset_qed_ready got %b want 0", qed_ready); else passed++;
    checks++; if (queue_count !== 5'd0) $display("FAIL reset_queue_count got %0d want 0", queue_count); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_bypass;
    logic ok;
    logic [31:0] sent[$];
    logic [31:0] w;
    qed_enable = 1'b0;
    got_q.delete();
    sent.push_back(32'hE061_1000);
    send(32'hE061_1000, ok);
    @(negedge clk);
    checks++; if (ok !== 1'b1) $display("FAIL bypass_accept got %b want 1", ok); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL bypass_valid got %b want 1", out_valid); else passed++;
    checks++; if (out_instr !== 32'hE061_1000) $display("FAIL bypass_instr got %h want e0611000", out_instr); else passed++;
    checks++; if (out_is_dup !== 1'b0) $display("FAIL bypass_dup got %b want 0", out_is_dup); else passed++;
    checks++; if (queue_count !== 5'd0) $display("FAIL bypass_count got %0d want 0", queue_count); else passed++;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      w = rand_instr(1'b0);
      sent.push_back(w);
      send(w, ok);
    end
    drain();
    checks++; if (got_q.size() != sent.size()) $display("FAIL bypass_stream_len got %0d want %0d", got_q.size(), sent.size()); else passed++;
    for (int i = 0; i < sent.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== {1'b0, sent[i]}) $display("FAIL bypass_stream[%0d] got %h want %h", i, got_q[i], {1'b0, sent[i]});
      else passed++;
    end
    checks++; if (queue_count !== 5'd0) $display("FAIL bypass_final_count got %0d want 0", queue_count); else passed++;
  endtask

  task automatic test_ignored_dup;
    int base;
    qed_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    base = ready_cnt;
    pulse_dup();
    repeat (5) @(negedge clk);
    checks++; if (ready_cnt != base) $display("FAIL empty_dup_pulse got %0d want %0d", ready_cnt, base); else passed++;
    checks++; if (queue_count !== 5'd0) $display("FAIL empty_dup_count got %0d want 0", queue_count); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL empty_dup_in_ready got %b want 1", in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_replay;
    logic [31:0] orig[$];
    logic ok;
    int n;
    for (int c = 0; c < 10; c++) begin
      orig.delete();
      case (c)
        0: begin orig.push_back(32'hE061_1000); orig.push_back(32'h9C85_0010); end
        1: begin orig.push_back(32'h84C1_0008); orig.push_back(32'hD401_1004); end
        2: begin orig.push_back(32'h0400_0010); orig.push_back(32'hE061_1000); end
        default: begin
          n = int'($urandom_range(1, 8));
          orig.push_back(rand_instr(1'b1));
          for (int i = 1; i < n; i++) orig.push_back(rand_instr(1'b0));
        end
      endcase
      do_replay(orig, c >= 5, ok);
      build_exp(orig);
      checks++; if (ok !== 1'b1) $display("FAIL replay%0d_handshake got %b want 1", c, ok); else passed++;
      checks++; if (got_q.size() != exp_q.size()) $display("FAIL replay%0d_len got %0d want %0d", c, got_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL replay%0d[%0d] got %h want %h", c, i, got_q[i], exp_q[i]);
        else passed++;
      end
      checks++; if (queue_count !== 5'd0) $display("FAIL replay%0d_count got %0d want 0", c, queue_count); else passed++;
    end
  endtask

  task automatic test_full;
    logic [31:0] orig[$];
    logic [31:0] w;
    logic s, ok;
    int base;
    got_q.delete();
    base = ready_cnt;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = rand_instr(1'b1);
      orig.push_back(w);
      send(w, s);
      if (!s) ok = 1'b0;
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else passed++;
    checks++; if (queue_count !== 5'd16) $display("FAIL full_count got %0d want 16", queue_count); else passed++;
    wait_ready(base + 1, s);
    if (!s) ok = 1'b0;
    drain();
    build_exp(orig);
    checks++; if (ok !== 1'b1) $display("FAIL full_progress got %b want 1", ok); else passed++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL full_len got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL full[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    send(32'hE061_1000, s);
    @(negedge clk);
    checks++; if (queue_count !== 5'd1) $display("FAIL full_back_to_orig got %0d want 1", queue_count); else passed++;
    @(posedge clk); #1;
    pulse_dup();
    wait_ready(base + 2, s);
    drain();
    checks++; if (s !== 1'b1) $display("FAIL full_followup_ready got %b want 1", s); else passed++;
  endtask

  task automatic test_backpressure;
    logic [31:0] orig[$];
    logic [31:0] held;
    logic [4:0] qc;
    logic s, found;
    int base;
    got_q.delete();
    base = ready_cnt;
    for (int i = 0; i < 6; i++) orig.push_back(rand_instr(1'b1));
    foreach (orig[i]) send(orig[i], s);
    pulse_dup();
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_is_dup) found = 1'b1;
    end
    checks++; if (found !== 1'b1) $display("FAIL bp_dup_start got %b want 1", found); else passed++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    held = out_instr;
    qc = queue_count;
    checks++; if (held !== ref_dup(orig[1])) $display("FAIL bp_held_value got %h want %h", held, ref_dup(orig[1])); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_instr !== held) $display("FAIL bp_hold_instr[%0d] got %h want %h", i, out_instr, held); else passed++;
      checks++; if (queue_count !== qc) $display("FAIL bp_hold_count[%0d] got %0d want %0d", i, queue_count, qc); else passed++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_ready(base + 1, s);
    drain();
    build_exp(orig);
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bp[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_enable_drop;
    logic [31:0] orig[$];
    logic s, found;
    int base;
    got_q.delete();
    base = ready_cnt;
    for (int i = 0; i < 3; i++) orig.push_back(rand_instr(1'b1));
    foreach (orig[i]) send(orig[i], s);
    pulse_dup();
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_is_dup) found = 1'b1;
    end
    @(posedge clk); #1;
    qed_enable = 1'b0;
    wait_ready(base + 1, s);
    drain();
    build_exp(orig);
    checks++; if ((found && s) !== 1'b1) $display("FAIL endrop_complete got %b want 1", found && s); else passed++;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL endrop_len got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL endrop[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    send(32'hE061_1000, s);
    @(negedge clk);
    checks++; if (queue_count !== 5'd0) $display("FAIL endrop_idle_count got %0d want 0", queue_count); else passed++;
    checks++; if (out_instr !== 32'hE061_1000) $display("FAIL endrop_idle_fwd got %h want e0611000", out_instr); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_dup;
    logic [31:0] orig[$];
    logic s, found;
    int base;
    qed_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) orig.push_back(rand_instr(1'b1));
    foreach (orig[i]) send(orig[i], s);
    base = ready_cnt;
    pulse_dup();
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (out_is_dup && queue_count == 5'd3) found = 1'b1;
    end
    checks++; if (found !== 1'b1) $display("FAIL rst_dup_pending got %b want 1", found); else passed++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    qed_enable = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", out_valid); else passed++;
    checks++; if (queue_count !== 5'd0) $display("FAIL rst_mid_count got %0d want 0", queue_count); else passed++;
    checks++; if (out_instr !== NOP) $display("FAIL rst_mid_instr got %h want %h", out_instr, NOP); else passed++;
    checks++; if (out_is_dup !== 1'b0) $display("FAIL rst_mid_dup got %b want 0", out_is_dup); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ready_cnt != base) $display("FAIL rst_mid_no_pulse got %0d want %0d", ready_cnt, base); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_idle_ready got %b want 1", in_ready); else passed++;
    @(posedge clk); #1;
    send(32'h9C85_0010, s);
    @(negedge clk);
    checks++; if (out_instr !== 32'h9C85_0010) $display("FAIL rst_mid_bypass got %h want 9c850010", out_instr); else passed++;
    checks++; if (queue_count !== 5'd0) $display("FAIL rst_mid_bypass_count got %0d want 0", queue_count); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_ignored_dup();
    test_replay();
    test_full();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_dup();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
